pic_host_link: RTL and testbench

- Synthesizable host-side engine for the port-A signalling protocol spoken by PIC16C57 convolution firmware. It is the bus master opposite the firmware.
- Watches the 4-bit code the PIC writes on port A.
- Feeds neighbourhood pixels on port B from a valid/ready source stream.
- Captures the 16-bit horizontal/vertical convolution results the PIC drives on {B,C}.
- Replaces the simulation-only host so the PIC core runs standalone on FPGA.

---
 rtl/pic_link_pkg.sv | 24 ++
 rtl/pic_port_sampler.sv | 40 ++++
 rtl/pic_host_link.sv | 187 ++++++++++++++++++
 tb/tb_pic_host_link.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pic_link_pkg.sv
// pic_link_pkg: shared port-A signal codes, link stages and port-B drive values.
package pic_link_pkg;
    localparam logic [3:0] CODE_READY   = 4'h1;
    localparam logic [3:0] CODE_BUSY    = 4'h4;
    localparam logic [3:0] CODE_CHECK   = 4'hA;
    localparam logic [3:0] CODE_RESULTH = 4'hD;
    localparam logic [3:0] CODE_RESULTV = 4'hE;
    localparam logic [3:0] CODE_END     = 4'hF;

    localparam logic [7:0] DRV_DONE = 8'hFF;
    localparam logic [7:0] DRV_MORE = 8'h00;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_READ,
        ST_RESULTH,
        ST_RESULTV,
        ST_END
    } stage_e;

    function automatic logic [7:0] drive_for(input logic finished);
        return finished ? DRV_DONE : DRV_MORE;
    endfunction
endpackage

// File: rtl/pic_port_sampler.sv
// pic_port_sampler: registers PIC ports A/B/C and flags a change of the port-A code.
//   clk, rst      : clock, synchronous active-high reset
//   a_i, b_i, c_i : raw PIC port values
//   evt_o         : registered A differs from the previously seen A
//   code_o        : registered A (the code that fired the event)
//   b_o, c_o      : registered B and C, captured with A
module pic_port_sampler (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a_i,
    input  logic [7:0] b_i,
    input  logic [7:0] c_i,
    output logic       evt_o,
    output logic [3:0] code_o,
    output logic [7:0] b_o,
    output logic [7:0] c_o
);
    logic [3:0] a_q, a_prev_q;
    logic [7:0] b_q, c_q;

    // a_prev only needs to follow a_q on an event; outside events they already match.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= 4'h0;
            b_q      <= 8'h00;
            c_q      <= 8'h00;
            a_prev_q <= 4'h0;
        end else begin
            a_q      <= a_i;
            b_q      <= b_i;
            c_q      <= c_i;
            a_prev_q <= a_q;
        end
    end

    assign evt_o  = a_q != a_prev_q;
    assign code_o = a_q;
    assign b_o    = b_q;
    assign c_o    = c_q;
endmodule

// File: rtl/pic_host_link.sv
// pic_host_link: host-side master for the PIC port-A convolution protocol.
//   port_a_in/b_in/c_in : PIC ports; port_b_out/c_out/bc_oe : host drive of B/C
//   pix_valid/data/ready, src_done : pixel source stream
//   res_valid/ready, res_h, res_v   : result pair sink
//   done, err_* (sticky), pix_count, res_count : status
module pic_host_link
    import pic_link_pkg::*;
#(
    parameter int NEIGHBOURS = 9,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       port_a_in,
    input  logic [7:0]       port_b_in,
    input  logic [7:0]       port_c_in,
    output logic [7:0]       port_b_out,
    output logic [7:0]       port_c_out,
    output logic             port_bc_oe,
    input  logic             pix_valid,
    input  logic [7:0]       pix_data,
    output logic             pix_ready,
    input  logic             src_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_h,
    output logic [15:0]      res_v,
    output logic             done,
    output logic             err_underrun,
    output logic             err_overrun,
    output logic             err_proto,
    output logic [CNT_W-1:0] pix_count,
    output logic [CNT_W-1:0] res_count
);
    logic       evt;
    logic [3:0] code;
    logic [7:0] b_s, c_s;

    pic_port_sampler u_sampler (
        .clk    (clk),
        .rst    (rst),
        .a_i    (port_a_in),
        .b_i    (port_b_in),
        .c_i    (port_c_in),
        .evt_o  (evt),
        .code_o (code),
        .b_o    (b_s),
        .c_o    (c_s)
    );

    stage_e           stage_q, stage_d;
    logic [7:0]       port_b_q, port_b_d;
    logic             oe_q, oe_d, pix_ready_q, pix_ready_d, res_valid_q, res_valid_d;
    logic [15:0]      res_h_q, res_h_d, res_v_q, res_v_d;
    logic             under_q, under_d, over_q, over_d, proto_q, proto_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, res_cnt_q, res_cnt_d, win_q, win_d;

    logic rdy, chk, rh, rv;
    assign rdy = evt && code == CODE_READY;
    assign chk = evt && code == CODE_CHECK;
    assign rh  = evt && code == CODE_RESULTH;
    assign rv  = evt && code == CODE_RESULTV;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q     <= ST_INIT;
            port_b_q    <= DRV_MORE;
            oe_q        <= 1'b1;
            pix_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_h_q     <= 16'h0000;
            res_v_q     <= 16'h0000;
            under_q     <= 1'b0;
            over_q      <= 1'b0;
            proto_q     <= 1'b0;
            seen_q      <= 1'b0;
            pix_cnt_q   <= '0;
            res_cnt_q   <= '0;
            win_q       <= '0;
        end else begin
            stage_q     <= stage_d;
            port_b_q    <= port_b_d;
            oe_q        <= oe_d;
            pix_ready_q <= pix_ready_d;
            res_valid_q <= res_valid_d;
            res_h_q     <= res_h_d;
            res_v_q     <= res_v_d;
            under_q     <= under_d;
            over_q      <= over_d;
            proto_q     <= proto_d;
            seen_q      <= seen_d;
            pix_cnt_q   <= pix_cnt_d;
            res_cnt_q   <= res_cnt_d;
            win_q       <= win_d;
        end
    end

    always_comb begin
        stage_d = stage_q;
        case (stage_q)
            ST_INIT:    if (chk) stage_d = src_done ? ST_END : ST_READ;
            ST_READ:    if (rh) stage_d = ST_RESULTH;
            ST_RESULTH: if (rv) stage_d = ST_RESULTV;
            ST_RESULTV: if (chk) stage_d = src_done ? ST_END : ST_READ;
            default:    stage_d = ST_END;
        endcase
    end

    // A new result in RESULTV overrides the handshake clear so res_valid stays high.
    always_comb begin
        port_b_d    = port_b_q;
        oe_d        = oe_q;
        pix_ready_d = 1'b0;
        res_valid_d = res_valid_q && !res_ready;
        res_h_d     = res_h_q;
        res_v_d     = res_v_q;
        under_d     = under_q;
        over_d      = over_q;
        proto_d     = proto_q;
        seen_d      = seen_q;
        pix_cnt_d   = pix_cnt_q;
        res_cnt_d   = res_cnt_q;
        win_d       = win_q;
        case (stage_q)
            ST_INIT: if (chk) port_b_d = drive_for(src_done);
            ST_READ: begin
                if (rdy && pix_valid) begin
                    port_b_d    = pix_data;
                    pix_ready_d = 1'b1;
                    pix_cnt_d   = pix_cnt_q + CNT_W'(1);
                    win_d       = win_q + CNT_W'(1);
                end
                if (rdy && !pix_valid) begin
                    port_b_d = DRV_MORE;
                    under_d  = 1'b1;
                end
                if (rh) begin
                    proto_d = proto_q | (win_q != CNT_W'(NEIGHBOURS));
                    win_d   = '0;
                    oe_d    = 1'b0;
                end
            end
            ST_RESULTH: begin
                if (rdy) begin
                    res_h_d = {b_s, c_s};
                    proto_d = proto_q | seen_q;
                    seen_d  = 1'b1;
                end
                if (rv) begin
                    proto_d = proto_q | !seen_q;
                    seen_d  = 1'b0;
                end
            end
            ST_RESULTV: begin
                if (rdy) begin
                    over_d      = over_q | (res_valid_q && !res_ready);
                    res_v_d     = {b_s, c_s};
                    res_valid_d = 1'b1;
                    res_cnt_d   = res_cnt_q + CNT_W'(1);
                end
                if (chk) begin
                    oe_d     = 1'b1;
                    port_b_d = drive_for(src_done);
                end
            end
            default: begin
                oe_d     = 1'b1;
                port_b_d = DRV_DONE;
            end
        endcase
    end

    assign port_b_out   = port_b_q;
    assign port_c_out   = 8'h00;
    assign port_bc_oe   = oe_q;
    assign pix_ready    = pix_ready_q;
    assign res_valid    = res_valid_q;
    assign res_h        = res_h_q;
    assign res_v        = res_v_q;
    assign done         = stage_q == ST_END;
    assign err_underrun = under_q;
    assign err_overrun  = over_q;
    assign err_proto    = proto_q;
    assign pix_count    = pix_cnt_q;
    assign res_count    = res_cnt_q;
endmodule

// File: tb/tb_pic_host_link.sv
// tb_pic_host_link: directed self-checking bench for pic_host_link.
module tb_pic_host_link;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  port_a_in;
    logic [7:0]  port_b_in, port_c_in, port_b_out, port_c_out, pix_data;
    logic        port_bc_oe, pix_valid, pix_ready, src_done, res_valid, res_ready;
    logic [15:0] res_h, res_v, pix_count, res_count;
    logic        done, err_underrun, err_overrun, err_proto;
    int          tests = 0;
    int          fails = 0;

    pic_host_link #(.NEIGHBOURS(9), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .port_a_in    (port_a_in),
        .port_b_in    (port_b_in),
        .port_c_in    (port_c_in),
        .port_b_out   (port_b_out),
        .port_c_out   (port_c_out),
        .port_bc_oe   (port_bc_oe),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (pix_ready),
        .src_done     (src_done),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_h        (res_h),
        .res_v        (res_v),
        .done         (done),
        .err_underrun (err_underrun),
        .err_overrun  (err_overrun),
        .err_proto    (err_proto),
        .pix_count    (pix_count),
        .res_count    (res_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write a code on port A and wait until its registered action is visible.
    task automatic step(input logic [3:0] code);
        port_a_in = code;
        tick(2);
    endtask

    task automatic pixel(input logic [7:0] val);
        pix_valid = 1'b1;
        pix_data  = val;
        step(4'h1);
        check("pix_out", {24'h0, port_b_out}, {24'h0, val});
        check("pix_ready_hi", {31'h0, pix_ready}, 32'h1);
        port_a_in = 4'h4;
        tick(1);
        check("pix_ready_lo", {31'h0, pix_ready}, 32'h0);
        tick(1);
    endtask

    task automatic check_reset_state();
        check("rst_b", {24'h0, port_b_out}, 32'h00);
        check("rst_c", {24'h0, port_c_out}, 32'h00);
        check("rst_oe", {31'h0, port_bc_oe}, 32'h1);
        check("rst_pix_ready", {31'h0, pix_ready}, 32'h0);
        check("rst_res_valid", {31'h0, res_valid}, 32'h0);
        check("rst_res_h", {16'h0, res_h}, 32'h0);
        check("rst_res_v", {16'h0, res_v}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_errs", {29'h0, err_underrun, err_overrun, err_proto}, 32'h0);
        check("rst_pix_count", {16'h0, pix_count}, 32'h0);
        check("rst_res_count", {16'h0, res_count}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        port_a_in = 4'h0;
        port_b_in = 8'h00;
        port_c_in = 8'h00;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        src_done  = 1'b0;
        res_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_reset_state();

        step(4'hA);
        check("init_check_b", {24'h0, port_b_out}, 32'h00);
        check("init_check_oe", {31'h0, port_bc_oe}, 32'h1);
        check("init_not_done", {31'h0, done}, 32'h0);

        for (int i = 0; i < 9; i++) pixel(8'h10 + 8'(i));
        check("pix_count9", {16'h0, pix_count}, 32'd9);
        check("no_err_after_win", {29'h0, err_underrun, err_overrun, err_proto}, 32'h0);

        port_b_in = 8'h12;
        port_c_in = 8'h34;
        step(4'hD);
        check("resh_oe", {31'h0, port_bc_oe}, 32'h0);
        step(4'h1);
        check("res_h1", {16'h0, res_h}, 32'h1234);
        step(4'hE);
        port_b_in = 8'hAB;
        port_c_in = 8'hCD;
        step(4'h1);
        check("res_v1", {16'h0, res_v}, 32'hABCD);
        check("res_valid1", {31'h0, res_valid}, 32'h1);
        check("res_count1", {16'h0, res_count}, 32'd1);
        check("proto_ok1", {31'h0, err_proto}, 32'h0);
        res_ready = 1'b1;
        tick(1);
        res_ready = 1'b0;
        check("res_valid_clr", {31'h0, res_valid}, 32'h0);

        step(4'hA);
        check("rv_check_oe", {31'h0, port_bc_oe}, 32'h1);
        check("rv_check_b", {24'h0, port_b_out}, 32'h00);

        pixel(8'h55);
        pix_valid = 1'b0;
        step(4'h1);
        check("under_b", {24'h0, port_b_out}, 32'h00);
        check("under_flag", {31'h0, err_underrun}, 32'h1);
        check("under_no_pulse", {31'h0, pix_ready}, 32'h0);
        port_a_in = 4'h4;
        tick(2);
        for (int i = 0; i < 7; i++) pixel(8'h60 + 8'(i));
        check("pix_count17", {16'h0, pix_count}, 32'd17);
        check("proto_before", {31'h0, err_proto}, 32'h0);
        step(4'hD);
        check("proto_short_win", {31'h0, err_proto}, 32'h1);

        port_b_in = 8'h11;
        port_c_in = 8'h11;
        step(4'h1);
        step(4'hE);
        port_b_in = 8'h22;
        port_c_in = 8'h22;
        step(4'h1);
        check("res_v2", {16'h0, res_v}, 32'h2222);
        check("no_over2", {31'h0, err_overrun}, 32'h0);
        check("res_count2", {16'h0, res_count}, 32'd2);
        step(4'hA);
        step(4'hD);
        port_b_in = 8'h44;
        port_c_in = 8'h44;
        step(4'h1);
        check("res_h3", {16'h0, res_h}, 32'h4444);
        step(4'hE);
        port_b_in = 8'h33;
        port_c_in = 8'h33;
        step(4'h1);
        check("over_flag", {31'h0, err_overrun}, 32'h1);
        check("res_v3", {16'h0, res_v}, 32'h3333);
        check("res_valid3", {31'h0, res_valid}, 32'h1);
        check("res_count3", {16'h0, res_count}, 32'd3);

        src_done = 1'b1;
        step(4'hA);
        check("end_b", {24'h0, port_b_out}, 32'hFF);
        check("end_oe", {31'h0, port_bc_oe}, 32'h1);
        check("end_done", {31'h0, done}, 32'h1);
        pix_valid = 1'b1;
        pix_data  = 8'h77;
        step(4'h1);
        check("end_ign_b", {24'h0, port_b_out}, 32'hFF);
        check("end_ign_pix", {16'h0, pix_count}, 32'd17);
        check("end_ign_ready", {31'h0, pix_ready}, 32'h0);
        step(4'hD);
        check("end_ign_oe", {31'h0, port_bc_oe}, 32'h1);
        check("end_still_done", {31'h0, done}, 32'h1);

        rst = 1'b1;
        tick(1);
        check_reset_state();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
